// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I integer register file.
package rv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd1;
    localparam reg_idx_t REG_SP   = 5'd2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback or flush.
// Set beats clear for the same index; lookups are combinational.
module reg_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          set_en_i,
    input  logic [AW-1:0] set_idx_i,
    input  logic          clr_en_i,
    input  logic [AW-1:0] clr_idx_i,
    input  logic          flush_i,
    input  logic [AW-1:0] rd1_idx_i,
    input  logic [AW-1:0] rd2_idx_i,
    output logic          rd1_pending_o,
    output logic          rd2_pending_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Clear first, then set, so a newer producer survives its predecessor's writeback.
    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = '0;
        end
        if (clr_en_i) begin
            pending_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign rd1_pending_o = pending_q[rd1_idx_i];
    assign rd2_pending_o = pending_q[rd2_idx_i];

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file: 2 combinational read ports with write bypass, 1 write port, pending scoreboard.
// After reset a clear sequence zeroes one entry per cycle; ready rises once every entry is written.
module reg_file_sb
    import rv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            ready
);

    localparam bit FULL_RANGE = (NREGS >= (1 << AW));

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic [XLEN-1:0] mem_q [NREGS];

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    logic run;
    logic wr_legal, issue_legal;
    logic rs1_ok, rs2_ok;
    logic hit1, hit2;
    logic rs1_pend, rs2_pend;

    // An index is usable when it addresses a real register other than a hardwired zero.
    function automatic logic idx_legal(input logic [AW-1:0] a);
        logic in_range;
        in_range = FULL_RANGE || (32'(a) < NREGS);
        return in_range && !(ZERO_REG && (a == AW'(REG_ZERO)));
    endfunction

    assign run         = (state_q == ST_RUN);
    assign wr_legal    = run && wr_en && idx_legal(wr_addr);
    assign issue_legal = run && issue_en && idx_legal(issue_rd);
    assign rs1_ok      = run && idx_legal(rs1_addr);
    assign rs2_ok      = run && idx_legal(rs2_addr);
    assign hit1        = BYPASS && wr_legal && (wr_addr == rs1_addr);
    assign hit2        = BYPASS && wr_legal && (wr_addr == rs2_addr);
    assign ready       = run;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = wr_legal;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d   = ST_RUN;
                    clr_idx_d = '0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_INIT;
                clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // No reset on the array so it can map onto RAM; the clear sequence zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_ok) begin
            rs1_data = hit1 ? wr_data : mem_q[rs1_addr];
        end
        if (rs2_ok) begin
            rs2_data = hit2 ? wr_data : mem_q[rs2_addr];
        end
    end

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .set_en_i      (issue_legal),
        .set_idx_i     (issue_rd),
        .clr_en_i      (wr_legal),
        .clr_idx_i     (wr_addr),
        .flush_i       (run && flush),
        .rd1_idx_i     (rs1_addr),
        .rd2_idx_i     (rs2_addr),
        .rd1_pending_o (rs1_pend),
        .rd2_pending_o (rs2_pend)
    );

    assign rs1_busy = rs1_ok && rs1_pend && !hit1;
    assign rs2_busy = rs2_ok && rs2_pend && !hit2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypassing and a non-bypassing instance share all stimulus.
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_rd;
    logic [31:0] wr_data;
    logic        wr_en, issue_en, flush;

    logic [31:0] rs1_data, rs2_data, nb_rs1_data, nb_rs2_data;
    logic        rs1_busy, rs2_busy, nb_rs1_busy, nb_rs2_busy;
    logic        ready, nb_ready;

    int checks = 0;
    int errors = 0;
    int cnt;

    reg_file_sb u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .ready    (ready)
    );

    reg_file_sb #(.BYPASS(1'b0)) u_nb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (nb_rs1_data),
        .rs2_data (nb_rs2_data),
        .rs1_busy (nb_rs1_busy),
        .rs2_busy (nb_rs2_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .ready    (nb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        issue_en = 1'b0;
        flush    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 32'h0;
        issue_rd = 5'd0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check({tag, "_rs1"}, rs1_data, 32'h0);
            check({tag, "_rs2"}, rs2_data, 32'h0);
            check({tag, "_busy"}, {31'h0, rs1_busy}, 32'h0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        idle_inputs();
        tick(); tick(); tick();
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_nb_ready", {31'h0, nb_ready}, 32'h0);

        // Release reset with traffic that the clear sequence must ignore.
        rst_n    = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 32'hAAAA_AAAA;
        issue_en = 1'b1;
        issue_rd = 5'd6;
        flush    = 1'b1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd6;
        cnt = 0;
        repeat (10) begin
            tick();
            cnt++;
        end
        check("init_ready", {31'h0, ready}, 32'h0);
        check("init_rs1_data", rs1_data, 32'h0);
        check("init_rs2_busy", {31'h0, rs2_busy}, 32'h0);
        check("init_nb_rs1_data", nb_rs1_data, 32'h0);
        while (!ready && cnt < 40) begin
            tick();
            cnt++;
        end
        idle_inputs();
        check("init_cycles", 32'(cnt), 32'd32);
        check("init_nb_ready", {31'h0, nb_ready}, 32'h1);
        read_all_zero("init_read");

        // Same-cycle write and read of x5.
        tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rs1_addr = 5'd5;
        #1;
        check("byp_rs1_data", rs1_data, 32'hDEAD_BEEF);
        check("nobyp_rs1_data", nb_rs1_data, 32'h0);
        tick();
        idle_inputs();
        #1;
        check("byp_rs1_next", rs1_data, 32'hDEAD_BEEF);
        check("nobyp_rs1_next", nb_rs1_data, 32'hDEAD_BEEF);

        // x0 is hardwired: writes and issues to it vanish.
        tick();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678;
        issue_en = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
        #1;
        check("x0_same_cycle", rs1_data, 32'h0);
        tick();
        idle_inputs();
        #1;
        check("x0_data", rs1_data, 32'h0);
        check("x0_busy", {31'h0, rs1_busy}, 32'h0);

        // Issue x7, write it back three cycles later.
        tick();
        issue_en = 1'b1; issue_rd = 5'd7; rs2_addr = 5'd7;
        #1;
        check("x7_busy_c0", {31'h0, rs2_busy}, 32'h0);
        tick();
        idle_inputs();
        #1;
        check("x7_busy_c1", {31'h0, rs2_busy}, 32'h1);
        tick();
        check("x7_busy_c2", {31'h0, rs2_busy}, 32'h1);
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        #1;
        check("x7_wb_busy", {31'h0, rs2_busy}, 32'h0);
        check("x7_wb_data", rs2_data, 32'h55);
        check("x7_nb_wb_busy", {31'h0, nb_rs2_busy}, 32'h1);
        check("x7_nb_wb_data", nb_rs2_data, 32'h0);
        tick();
        idle_inputs();
        #1;
        check("x7_after_busy", {31'h0, rs2_busy}, 32'h0);
        check("x7_nb_after_busy", {31'h0, nb_rs2_busy}, 32'h0);
        check("x7_after_data", rs2_data, 32'h55);

        // Issue and writeback to x9 together: the newer producer stays pending.
        tick();
        issue_en = 1'b1; issue_rd = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99; rs1_addr = 5'd9;
        #1;
        check("x9_same_busy", {31'h0, rs1_busy}, 32'h0);
        check("x9_same_data", rs1_data, 32'h99);
        tick();
        idle_inputs();
        #1;
        check("x9_pending", {31'h0, rs1_busy}, 32'h1);
        check("x9_nb_pending", {31'h0, nb_rs1_busy}, 32'h1);
        check("x9_data", rs1_data, 32'h99);

        // Flush with a concurrent issue of x3 and a write of x10.
        tick();
        issue_en = 1'b1; issue_rd = 5'd4;
        tick();
        issue_rd = 5'd3; flush = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hA0A0_A0A0; rs1_addr = 5'd4;
        #1;
        check("x4_pre_flush", {31'h0, rs1_busy}, 32'h1);
        tick();
        idle_inputs();
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        check("flush_x3_busy", {31'h0, rs1_busy}, 32'h1);
        check("flush_x4_busy", {31'h0, rs2_busy}, 32'h0);
        rs1_addr = 5'd9; rs2_addr = 5'd10;
        #1;
        check("flush_x9_busy", {31'h0, rs1_busy}, 32'h0);
        check("flush_x10_data", rs2_data, 32'hA0A0_A0A0);
        rs1_addr = 5'd10;
        #1;
        check("dual_rs1_x10", rs1_data, 32'hA0A0_A0A0);
        check("dual_rs2_x10", rs2_data, 32'hA0A0_A0A0);
        check("dual_nb_x10", nb_rs1_data, 32'hA0A0_A0A0);
        rs1_addr = 5'd3;

        // Mid-run reset pulse.
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'h0, ready}, 32'h0);
        check("midrst_nb_ready", {31'h0, nb_ready}, 32'h0);
        check("midrst_x3_busy", {31'h0, rs1_busy}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        while (!ready && cnt < 40) begin
            tick();
            cnt++;
        end
        check("rerun_cycles", 32'(cnt), 32'd32);
        read_all_zero("rerun_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
